uart_csr_sched: RTL and testbench
=================================

UART_CSR_SCHED -- requirements
Module: uart_csr_sched

Interface
REQ-001 Parameters (name, default, meaning) SHALL be:
- CSR_RXTX_ADDR, 14'h0000, UART data register address.
- CSR_DIV_ADDR, 14'h0001, UART divisor register address.
- DIVISOR, 16'd27, baud divisor written at start-up.
- TX_TIMEOUT, 16'd65535, max cycles waited for tx_irq.

REQ-002 Ports (name, direction, width, meaning) SHALL be:
- sys_clk  in  1  single clock, rising edge.
- sys_rst_n  in  1  asynchronous, active-low reset.
- a_valid  in  1  requester A byte offered.
- a_data  in  8  requester A byte.
- a_ready  out  1  requester A byte accepted.
- b_valid  in  1  requester B byte offered.
- b_data  in  8  requester B byte.
- b_ready  out  1  requester B byte accepted.
- rx_data  out  8  received byte.
- rx_valid  out  1  rx_data holds an unread byte.
- rx_ready  in  1  consumer takes the byte.
- rx_overflow  out  1  one-cycle pulse: received byte dropped.
- tx_timeout  out  1  one-cycle pulse: tx_irq never arrived.
- busy  out  1  FSM not in IDLE.
- csr_a  out  14  UART CSR address.
- csr_we  out  1  UART CSR write strobe.
- csr_di  out  32  UART CSR write data.
- csr_do  in  32  UART CSR read data, valid one cycle after csr_a.
- rx_irq  in  1  UART byte received (pulse).
- tx_irq  in  1  UART transmit done (pulse).

Function
REQ-003 FSM states SHALL be CFG, IDLE, TX_WAIT, RX_RD, RX_CAP; csr_a, csr_we and csr_di SHALL be registered.
REQ-004 CFG: at the first clock edge, csr_we<=1, csr_a<=CSR_DIV_ADDR, csr_di<={16'b0,DIVISOR}, then go to IDLE; csr_we SHALL be high for exactly one cycle.
REQ-005 rx_irq SHALL set the sticky rx_pend flag in any state; rx_pend clears on entry to RX_RD; rx_irq coincident with that clear SHALL keep rx_pend set.
REQ-006 IDLE with rx_pend=1 SHALL go to RX_RD with csr_a<=CSR_RXTX_ADDR, csr_we<=0; RX has priority over TX.
REQ-007 RX_RD SHALL go to RX_CAP unconditionally.
REQ-008 RX_CAP SHALL sample csr_do[7:0] and return to IDLE:
- if rx_valid=0, or rx_valid&rx_ready that cycle: load rx_data, rx_valid<=1.
- otherwise: drop the byte and pulse rx_overflow for one cycle.
REQ-009 rx_valid SHALL clear on the edge where rx_valid&rx_ready, unless REQ-008 reloads it on that edge.
REQ-010 Arbitration (IDLE, rx_pend=0) SHALL be round-robin:
- a_ready/b_ready are combinational and at most one is high.
- With both valid, grant goes to the requester not last granted.
- The rr pointer resets to "B last", so A wins the first tie.
- ready SHALL be 0 outside IDLE and when rx_pend=1.
REQ-011 On grant at edge N: at N+1, csr_we=1, csr_a=CSR_RXTX_ADDR, csr_di={24'b0,data}; state goes to TX_WAIT; the timeout counter clears.
REQ-012 TX_WAIT SHALL:
- return to IDLE on tx_irq.
- on reaching TX_TIMEOUT cycles without tx_irq, pulse tx_timeout and return to IDLE.
- ignore tx_irq in every other state.
REQ-013 csr_we SHALL be 0 in every cycle not covered by REQ-004 or REQ-011; csr_a and csr_di SHALL hold their last value.
REQ-014 busy SHALL be combinational, equal to (state != IDLE).

Reset
REQ-015 While sys_rst_n=0, all state SHALL clear immediately, independent of sys_clk:
- state=CFG, rr pointer="B last", rx_pend=0, counter=0.
- csr_we=0, csr_a=0, csr_di=0, rx_data=0, rx_valid=0, rx_overflow=0, tx_timeout=0, a_ready=0, b_ready=0, busy=1.
REQ-016 Reset asserted mid-transfer SHALL abandon the transfer with no further csr_we; after release the sequence restarts with the CFG write.

Verification
REQ-017 Release reset -> first cycle after the first edge: csr_we=1, csr_a=14'h0001, csr_di=32'h0000001B; next cycle csr_we=0, busy=0.
REQ-018 a_valid=b_valid=1, a_data=8'h41, b_data=8'h42, tx_irq 10 cycles after each write -> writes in order 32'h41 then 32'h42 to csr_a=0, one cycle each.
REQ-019 rx_irq pulse during TX_WAIT, csr_do=32'h5A -> after tx_irq: RX_RD, RX_CAP, then rx_data=8'h5A, rx_valid=1 before any further TX grant.
REQ-020 rx_valid=1 held with rx_ready=0, second rx_irq -> rx_overflow high for exactly one cycle; rx_data unchanged.
REQ-021 TX_TIMEOUT=16 and no tx_irq -> tx_timeout pulses once 16 cycles after csr_we; FSM returns to IDLE; the next request is granted.
REQ-022 sys_rst_n low for 1 cycle during TX_WAIT -> all outputs at REQ-015 values; after release the CFG write repeats.

Source files
------------

// File: rtl/uart_csr_sched_if.sv
// Requester, receive-side and UART CSR bus signals of the scheduler.
// The master modport is the scheduler itself; slave is its environment.
interface uart_csr_sched_if;
  logic        a_valid;
  logic [7:0]  a_data;
  logic        a_ready;
  logic        b_valid;
  logic [7:0]  b_data;
  logic        b_ready;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic        rx_ready;
  logic        rx_overflow;
  logic        tx_timeout;
  logic        busy;
  logic [13:0] csr_a;
  logic        csr_we;
  logic [31:0] csr_di;
  logic [31:0] csr_do;
  logic        rx_irq;
  logic        tx_irq;

  modport master (
    input  a_valid, a_data, b_valid, b_data, rx_ready, csr_do, rx_irq, tx_irq,
    output a_ready, b_ready, rx_data, rx_valid, rx_overflow, tx_timeout, busy,
           csr_a, csr_we, csr_di
  );

  modport slave (
    output a_valid, a_data, b_valid, b_data, rx_ready, csr_do, rx_irq, tx_irq,
    input  a_ready, b_ready, rx_data, rx_valid, rx_overflow, tx_timeout, busy,
           csr_a, csr_we, csr_di
  );
endinterface

// File: rtl/uart_csr_sched.sv
// Schedules two byte requesters and received-byte reads onto a single UART CSR port.
// Programs the baud divisor once after reset, then arbitrates round-robin with RX first.
//
// state     | meaning
// S_CFG     | write divisor register, once after reset
// S_IDLE    | arbitrate: pending RX read first, else round-robin TX grant
// S_TX_WAIT | byte written, waiting for tx_irq or timeout
// S_RX_RD   | data register address presented
// S_RX_CAP  | read data valid, capture or drop the byte
module uart_csr_sched #(
  parameter logic [13:0] CSR_RXTX_ADDR = 14'h0000,
  parameter logic [13:0] CSR_DIV_ADDR  = 14'h0001,
  parameter logic [15:0] DIVISOR       = 16'd27,
  parameter logic [15:0] TX_TIMEOUT    = 16'd65535
) (
  input logic              sys_clk,
  input logic              sys_rst_n,
  uart_csr_sched_if.master bus
);

  typedef enum logic [2:0] {
    S_CFG,
    S_IDLE,
    S_TX_WAIT,
    S_RX_RD,
    S_RX_CAP
  } state_t;

  state_t      state_q;
  logic        rr_last_b_q;
  logic        rx_pend_q;
  logic        rx_pend_d;
  logic [15:0] cnt_q;
  logic [13:0] csr_a_q;
  logic        csr_we_q;
  logic [31:0] csr_di_q;
  logic [7:0]  rx_data_q;
  logic        rx_valid_q;
  logic        rx_ovf_q;
  logic        tx_tmo_q;

  logic arb_ok;
  logic gnt_a;
  logic gnt_b;
  logic rx_take;
  logic rx_enter;

  always_comb begin
    arb_ok    = (state_q == S_IDLE) && !rx_pend_q;
    gnt_a     = arb_ok && bus.a_valid && (!bus.b_valid || rr_last_b_q);
    gnt_b     = arb_ok && bus.b_valid && !gnt_a;
    rx_take   = rx_valid_q && bus.rx_ready;
    rx_enter  = (state_q == S_IDLE) && rx_pend_q;
    // a fresh rx_irq on the clearing edge must survive the clear
    rx_pend_d = bus.rx_irq || (rx_pend_q && !rx_enter);
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state_q     <= S_CFG;
      rr_last_b_q <= 1'b1;
      rx_pend_q   <= 1'b0;
      cnt_q       <= '0;
      csr_a_q     <= '0;
      csr_we_q    <= 1'b0;
      csr_di_q    <= '0;
      rx_data_q   <= '0;
      rx_valid_q  <= 1'b0;
      rx_ovf_q    <= 1'b0;
      tx_tmo_q    <= 1'b0;
    end else begin
      csr_we_q  <= 1'b0;
      rx_ovf_q  <= 1'b0;
      tx_tmo_q  <= 1'b0;
      rx_pend_q <= rx_pend_d;
      if (rx_take) rx_valid_q <= 1'b0;

      case (state_q)
        S_CFG: begin
          csr_we_q <= 1'b1;
          csr_a_q  <= CSR_DIV_ADDR;
          csr_di_q <= {16'b0, DIVISOR};
          state_q  <= S_IDLE;
        end
        S_IDLE: begin
          if (rx_pend_q) begin
            csr_a_q <= CSR_RXTX_ADDR;
            state_q <= S_RX_RD;
          end else if (gnt_a || gnt_b) begin
            csr_we_q    <= 1'b1;
            csr_a_q     <= CSR_RXTX_ADDR;
            csr_di_q    <= {24'b0, gnt_a ? bus.a_data : bus.b_data};
            rr_last_b_q <= gnt_b;
            cnt_q       <= '0;
            state_q     <= S_TX_WAIT;
          end
        end
        S_TX_WAIT: begin
          if (bus.tx_irq) begin
            state_q <= S_IDLE;
          end else if (cnt_q == TX_TIMEOUT - 16'd1) begin
            tx_tmo_q <= 1'b1;
            state_q  <= S_IDLE;
          end else begin
            cnt_q <= cnt_q + 16'd1;
          end
        end
        S_RX_RD: state_q <= S_RX_CAP;
        S_RX_CAP: begin
          if (!rx_valid_q || rx_take) begin
            rx_data_q  <= bus.csr_do[7:0];
            rx_valid_q <= 1'b1;
          end else begin
            rx_ovf_q <= 1'b1;
          end
          state_q <= S_IDLE;
        end
        default: state_q <= S_CFG;
      endcase
    end
  end

  assign bus.a_ready     = gnt_a;
  assign bus.b_ready     = gnt_b;
  assign bus.rx_data     = rx_data_q;
  assign bus.rx_valid    = rx_valid_q;
  assign bus.rx_overflow = rx_ovf_q;
  assign bus.tx_timeout  = tx_tmo_q;
  assign bus.busy        = (state_q != S_IDLE);
  assign bus.csr_a       = csr_a_q;
  assign bus.csr_we      = csr_we_q;
  assign bus.csr_di      = csr_di_q;

endmodule

// File: tb/tb_uart_csr_sched.sv
// Randomized and directed bench for uart_csr_sched against a transaction-phase model.
// The model tracks which phase the scheduler should be in and what the CSR port must show.
module tb_uart_csr_sched;
  localparam logic [15:0] TMO = 16'd16;
  localparam int PH_CFG = 0, PH_IDLE = 1, PH_TXW = 2, PH_RXRD = 3, PH_RXCAP = 4;

  logic sys_clk   = 1'b0;
  logic sys_rst_n = 1'b1;

  uart_csr_sched_if bus ();

  uart_csr_sched #(.TX_TIMEOUT(TMO)) dut (
    .sys_clk  (sys_clk),
    .sys_rst_n(sys_rst_n),
    .bus      (bus)
  );

  always #5 sys_clk = ~sys_clk;

  int n_cmp = 0;
  int n_bad = 0;
  bit chk_en = 1'b0;

  // model state
  int          m_ph;
  logic        m_last_b;
  logic        m_pend;
  int          m_wait;
  logic        e_we, e_rxv, e_ovf, e_tmo;
  logic [13:0] e_a;
  logic [31:0] e_di;
  logic [7:0]  e_rxd;

  // stimulus state
  logic [7:0] uart_byte;
  int         tx_cd;
  int         tx_delay;
  bit         spur;
  int         cyc;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic exp_a_rdy();
    return (m_ph == PH_IDLE) && !m_pend && bus.a_valid && (!bus.b_valid || m_last_b);
  endfunction

  function automatic logic exp_b_rdy();
    return (m_ph == PH_IDLE) && !m_pend && bus.b_valid && (!bus.a_valid || !m_last_b);
  endfunction

  task automatic model_step();
    logic ga, gb, was_v, take, pend_clr;
    if (!sys_rst_n) begin
      m_ph = PH_CFG; m_last_b = 1'b1; m_pend = 1'b0; m_wait = 0;
      e_we = 1'b0; e_a = '0; e_di = '0; e_rxd = '0; e_rxv = 1'b0; e_ovf = 1'b0; e_tmo = 1'b0;
    end else begin
      ga = exp_a_rdy();
      gb = exp_b_rdy();
      was_v = e_rxv;
      take = was_v && bus.rx_ready;
      pend_clr = 1'b0;
      e_we = 1'b0; e_ovf = 1'b0; e_tmo = 1'b0;
      if (take) e_rxv = 1'b0;
      case (m_ph)
        PH_CFG: begin
          e_we = 1'b1; e_a = 14'h0001; e_di = 32'd27; m_ph = PH_IDLE;
        end
        PH_IDLE: begin
          if (m_pend) begin
            pend_clr = 1'b1; e_a = 14'h0000; m_ph = PH_RXRD;
          end else if (ga || gb) begin
            e_we = 1'b1; e_a = 14'h0000;
            e_di = {24'h0, ga ? bus.a_data : bus.b_data};
            m_last_b = gb; m_wait = 0; m_ph = PH_TXW;
          end
        end
        PH_TXW: begin
          if (bus.tx_irq) m_ph = PH_IDLE;
          else begin
            m_wait++;
            if (m_wait == int'(TMO)) begin
              e_tmo = 1'b1; m_ph = PH_IDLE;
            end
          end
        end
        PH_RXRD: m_ph = PH_RXCAP;
        default: begin
          if (!was_v || take) begin
            e_rxd = bus.csr_do[7:0]; e_rxv = 1'b1;
          end else e_ovf = 1'b1;
          m_ph = PH_IDLE;
        end
      endcase
      m_pend = (m_pend && !pend_clr) || bus.rx_irq;
    end
  endtask

  initial forever begin
    @(posedge sys_clk or negedge sys_rst_n);
    model_step();
  end

  initial forever begin
    @(negedge sys_clk);
    if (chk_en) begin
      chk("csr_we",      32'(bus.csr_we),      32'(e_we));
      chk("csr_a",       32'(bus.csr_a),       32'(e_a));
      chk("csr_di",      bus.csr_di,           e_di);
      chk("rx_data",     32'(bus.rx_data),     32'(e_rxd));
      chk("rx_valid",    32'(bus.rx_valid),    32'(e_rxv));
      chk("rx_overflow", 32'(bus.rx_overflow), 32'(e_ovf));
      chk("tx_timeout",  32'(bus.tx_timeout),  32'(e_tmo));
      chk("busy",        32'(bus.busy),        32'(m_ph != PH_IDLE));
      chk("a_ready",     32'(bus.a_ready),     32'(exp_a_rdy()));
      chk("b_ready",     32'(bus.b_ready),     32'(exp_b_rdy()));
    end
  end

  // One clock; UART read data follows the address one cycle later, tx_irq answers TX writes.
  task automatic step();
    logic rd;
    rd = (bus.csr_a == 14'h0000) && !bus.csr_we;
    @(posedge sys_clk);
    #1;
    cyc++;
    bus.csr_do = rd ? {24'h0, uart_byte} : {24'hFFFFFF, ~uart_byte};
    bus.rx_irq = 1'b0;
    bus.tx_irq = 1'b0;
    if (!sys_rst_n) tx_cd = 0;
    else if (e_we && e_a == 14'h0000) tx_cd = tx_delay;
    else if (tx_cd > 0) begin
      tx_cd--;
      bus.tx_irq = (tx_cd == 0);
    end
    if (spur && $urandom_range(0, 24) == 0) bus.tx_irq = 1'b1;
  endtask

  task automatic wait_write(input int bound, output logic [31:0] di, output int at);
    di = '0;
    at = -1;
    for (int i = 0; i < bound; i++) begin
      step();
      if (bus.csr_we && bus.csr_a == 14'h0000) begin
        di = bus.csr_di;
        at = cyc;
        break;
      end
    end
    chk("write_seen", 32'(at >= 0), 32'h1);
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_we"},    32'(bus.csr_we),      32'h0);
    chk({tag, "_a"},     32'(bus.csr_a),       32'h0);
    chk({tag, "_di"},    bus.csr_di,           32'h0);
    chk({tag, "_rxd"},   32'(bus.rx_data),     32'h0);
    chk({tag, "_rxv"},   32'(bus.rx_valid),    32'h0);
    chk({tag, "_ovf"},   32'(bus.rx_overflow), 32'h0);
    chk({tag, "_tmo"},   32'(bus.tx_timeout),  32'h0);
    chk({tag, "_ardy"},  32'(bus.a_ready),     32'h0);
    chk({tag, "_brdy"},  32'(bus.b_ready),     32'h0);
    chk({tag, "_busy"},  32'(bus.busy),        32'h1);
  endtask

  task automatic check_cfg_write(input string tag);
    chk({tag, "_we"}, 32'(bus.csr_we), 32'h1);
    chk({tag, "_a"},  32'(bus.csr_a),  32'h0001);
    chk({tag, "_di"}, bus.csr_di,      32'h0000001B);
  endtask

  logic [31:0] wd [2];
  int          wc [2];
  logic [31:0] di;
  int          t0, t1, nw, pulses;
  bit          got_rx;

  initial begin
    bus.a_valid = 1'b0; bus.a_data = '0; bus.b_valid = 1'b0; bus.b_data = '0;
    bus.rx_ready = 1'b0; bus.csr_do = '0; bus.rx_irq = 1'b0; bus.tx_irq = 1'b0;
    uart_byte = 8'h00; tx_cd = 0; tx_delay = 10; spur = 1'b0; cyc = 0;

    #2 sys_rst_n = 1'b0;
    #1 chk_en = 1'b1;
    check_reset_outputs("por");
    step();
    step();
    sys_rst_n = 1'b1;

    // divisor write right after release, then idle
    step();
    check_cfg_write("cfg");
    step();
    chk("cfg_we_off", 32'(bus.csr_we), 32'h0);
    chk("cfg_idle",   32'(bus.busy),   32'h0);

    // tie between A and B: A first after reset, then B
    tx_delay = 10;
    bus.a_data = 8'h41; bus.b_data = 8'h42; bus.a_valid = 1'b1; bus.b_valid = 1'b1;
    nw = 0;
    wd[0] = '0; wd[1] = '0; wc[0] = 0; wc[1] = 0;
    for (int i = 0; i < 60 && nw < 2; i++) begin
      step();
      if (bus.csr_we && bus.csr_a == 14'h0000) begin
        wd[nw] = bus.csr_di;
        wc[nw] = cyc;
        nw++;
      end
    end
    bus.a_valid = 1'b0; bus.b_valid = 1'b0;
    chk("rr_writes", 32'(nw),            32'd2);
    chk("rr_first",  wd[0],              32'h00000041);
    chk("rr_second", wd[1],              32'h00000042);
    chk("rr_gap",    32'(wc[1] - wc[0]), 32'd12);
    repeat (14) step();

    // no tx_irq: timeout pulse 16 cycles after the write, then next request granted
    tx_delay = 0;
    bus.a_data = 8'h33; bus.a_valid = 1'b1;
    wait_write(10, di, t0);
    bus.a_valid = 1'b0;
    chk("tmo_di", di, 32'h00000033);
    t1 = -1000; pulses = 0;
    for (int i = 0; i < 30; i++) begin
      step();
      if (bus.tx_timeout) begin
        pulses++;
        t1 = cyc;
      end
    end
    chk("tmo_latency", 32'(t1 - t0), 32'd16);
    chk("tmo_pulses",  32'(pulses),  32'd1);
    tx_delay = 3;
    bus.b_data = 8'h66; bus.b_valid = 1'b1;
    wait_write(10, di, t0);
    bus.b_valid = 1'b0;
    chk("post_tmo_di", di, 32'h00000066);
    repeat (8) step();

    // byte received during TX wait is delivered before the next TX grant
    tx_delay = 6;
    bus.a_data = 8'h11; bus.a_valid = 1'b1;
    wait_write(10, di, t0);
    step();
    step();
    uart_byte = 8'h5A;
    bus.rx_irq = 1'b1;
    got_rx = 1'b0;
    t1 = -1;
    for (int i = 0; i < 30; i++) begin
      step();
      if (bus.rx_valid && !got_rx) begin
        got_rx = 1'b1;
        chk("rx_byte", 32'(bus.rx_data), 32'h5A);
      end
      if (bus.csr_we && bus.csr_a == 14'h0000) begin
        t1 = cyc;
        break;
      end
    end
    bus.a_valid = 1'b0;
    chk("rx_before_tx",  32'(got_rx),  32'h1);
    chk("tx_after_rx",   32'(t1 > 0),  32'h1);
    repeat (10) step();

    // unread byte held: second byte dropped with one overflow pulse
    uart_byte = 8'h77;
    bus.rx_irq = 1'b1;
    pulses = 0;
    for (int i = 0; i < 15; i++) begin
      step();
      if (bus.rx_overflow) pulses++;
    end
    chk("ovf_pulses", 32'(pulses),       32'd1);
    chk("ovf_keep",   32'(bus.rx_data),  32'h5A);
    chk("ovf_valid",  32'(bus.rx_valid), 32'h1);
    bus.rx_ready = 1'b1;
    step();
    bus.rx_ready = 1'b0;
    step();
    chk("rx_consumed", 32'(bus.rx_valid), 32'h0);

    // reset during TX wait abandons the transfer and restarts with the divisor write
    tx_delay = 0;
    bus.a_data = 8'h22; bus.a_valid = 1'b1;
    wait_write(10, di, t0);
    repeat (3) step();
    sys_rst_n = 1'b0;
    #1;
    check_reset_outputs("mid");
    step();
    sys_rst_n = 1'b1;
    step();
    check_cfg_write("recfg");
    bus.a_valid = 1'b0;
    repeat (20) step();

    // randomized traffic
    spur = 1'b1;
    for (int i = 0; i < 3000; i++) begin
      step();
      if (i == 1500) begin
        sys_rst_n = 1'b0;
        step();
        sys_rst_n = 1'b1;
      end
      bus.a_valid  = ($urandom_range(0, 2) != 0);
      bus.b_valid  = ($urandom_range(0, 2) != 0);
      bus.a_data   = 8'($urandom);
      bus.b_data   = 8'($urandom);
      bus.rx_ready = ($urandom_range(0, 1) == 1);
      tx_delay     = $urandom_range(0, 20);
      if ($urandom_range(0, 14) == 0) begin
        uart_byte  = 8'($urandom);
        bus.rx_irq = 1'b1;
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
